dsram_req_ctrl: RTL and testbench
=================================

// Module: dsram_req_ctrl
// PURPOSE
//  Sequences the data-SRAM port for the EXE/MEM pipeline stages using a req/addr_ok/data_ok handshake.
//  EXE issues a load/store request. The block holds the bus fields stable until addr_ok.
//  It then tracks the single outstanding transaction and delivers data_ok/rdata to MEM, which drives mem_ready_go.
//  Flushed transactions are completed on the bus but their responses are silently discarded.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width; strobe width = DATA_W/8
// PORTS
//  clk             in   1         clock
//  reset           in   1         synchronous, active-high reset
//  exe_req_valid   in   1         EXE holds a valid memory op
//  exe_req_wr      in   1         1=store, 0=load
//  exe_req_size    in   2         0=byte 1=half 2=word
//  exe_req_addr    in   ADDR_W    byte address
//  exe_req_wdata   in   DATA_W    store data
//  exe_req_wstrb   in   DATA_W/8  byte enables
//  exe_req_accept  out  1         request taken by bus this cycle; EXE may advance
//  mem_data_ready  out  1         response available for MEM (drives mem_ready_go)
//  mem_rdata       out  DATA_W    load data, valid while mem_data_ready
//  mem_advance     in   1         MEM hands to WB this cycle (consumes response)
//  flush           in   1         cancel in-flight op (exception/ertn)
//  data_sram_req   out  1         bus request
//  data_sram_wr    out  1         bus write flag
//  data_sram_size  out  2         bus size
//  data_sram_addr  out  ADDR_W    bus address
//  data_sram_wdata out  DATA_W    bus write data
//  data_sram_wstrb out  DATA_W/8  bus strobes
//  data_sram_addr_ok  in  1       bus accepted request
//  data_sram_data_ok  in  1       bus response (read data or write ack), in order
//  data_sram_rdata    in  DATA_W  bus read data
// BEHAVIOUR
//  Reset: state=IDLE, drop=0, buffer=0; all outputs 0 in the cycle after reset is sampled.
//  At most one outstanding transaction. Responses are never reordered.
//  IDLE:
//   - data_sram_req = exe_req_valid & ~flush. Bus fields pass through combinationally from exe_req_*.
//   - addr_ok same cycle -> exe_req_accept=1, go WAIT_DATA.
//   - Req asserted, no addr_ok -> latch exe_req_* into hold regs, go WAIT_ADDR.
//  WAIT_ADDR:
//   - req=1, bus fields from hold regs (stable even if exe_req_* changes).
//   - flush sets drop=1; req is never withdrawn.
//   - addr_ok -> go WAIT_DATA; exe_req_accept = ~drop & ~flush.
//  WAIT_DATA:
//   - req=0, exe_req_accept=0. flush sets drop=1.
//   - data_ok with (drop|flush) -> discard response, drop<=0, go IDLE.
//   - data_ok & mem_advance -> mem_data_ready=1, mem_rdata=data_sram_rdata (bypass), go IDLE.
//   - data_ok & ~mem_advance -> latch rdata into buffer, go DATA_BUF.
//  DATA_BUF:
//   - mem_data_ready=1, mem_rdata=buffer, req=0.
//   - mem_advance -> go IDLE. flush -> go IDLE, response dropped.
//   - No new request is issued until the state returns to IDLE.
//  Timing and exclusions:
//   - Minimum latency: request cycle N (addr_ok), mem_data_ready at cycle N+1 with zero-wait data_ok.
//   - mem_data_ready is never 1 for a dropped transaction.
//   - Stores follow the same path; mem_rdata is don't-care for stores.
//  Reset mid-transaction: state returns to IDLE. The bus side is reset together with the core.
// TESTING
//  1. Load, addr_ok in cycle 0, data_ok+rdata=0x12345678 in cycle 1, mem_advance=1 -> accept@0, ready@1, mem_rdata=0x12345678, IDLE@2.
//  2. Store to 0x1000; addr_ok held low 3 cycles while exe_req_addr changes to 0x2000 -> data_sram_addr stays 0x1000, req high 4 cycles, accept only on the addr_ok cycle.
//  3. flush in WAIT_DATA, data_ok+0xDEADBEEF 2 cycles later -> mem_data_ready stays 0. A back-to-back request issues in the following IDLE cycle.
//  4. flush in WAIT_ADDR, addr_ok next cycle -> exe_req_accept=0, response discarded, drop cleared.
//  5. data_ok with mem_advance=0 for 2 cycles, then 1 -> mem_data_ready=1 for 3 cycles with constant buffered rdata; no bus req meanwhile.
//  6. reset asserted in WAIT_ADDR and in DATA_BUF -> next cycle req=0, accept=0, ready=0, state IDLE.

Source files
------------

// File: rtl/dsram_req_ctrl_if.sv
// Data-SRAM request/response bus: req/addr_ok command phase, data_ok/rdata response phase.
interface dsram_req_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  data_sram_req;
  logic                  data_sram_wr;
  logic [1:0]            data_sram_size;
  logic [ADDR_W-1:0]     data_sram_addr;
  logic [DATA_W-1:0]     data_sram_wdata;
  logic [DATA_W/8-1:0]   data_sram_wstrb;
  logic                  data_sram_addr_ok;
  logic                  data_sram_data_ok;
  logic [DATA_W-1:0]     data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wdata, data_sram_wstrb,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wdata, data_sram_wstrb,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/dsram_req_ctrl.sv
// Data-SRAM port sequencer between EXE (request) and MEM (response) with a single
// outstanding transaction; flushed transactions finish on the bus but are discarded.
module dsram_req_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                exe_req_valid,
  input  logic                exe_req_wr,
  input  logic [1:0]          exe_req_size,
  input  logic [ADDR_W-1:0]   exe_req_addr,
  input  logic [DATA_W-1:0]   exe_req_wdata,
  input  logic [DATA_W/8-1:0] exe_req_wstrb,
  output logic                exe_req_accept,
  output logic                mem_data_ready,
  output logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_advance,
  input  logic                flush,
  dsram_req_ctrl_if.master    sram
);
  localparam int STRB_W = DATA_W / 8;
  localparam int HOLD_W = 1 + 2 + ADDR_W + DATA_W + STRB_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ADDR = 2'd1;
  localparam logic [1:0] ST_WAIT_DATA = 2'd2;
  localparam logic [1:0] ST_DATA_BUF  = 2'd3;

  logic [1:0]        state_d, state_q;
  logic              drop_d, drop_q;
  logic [DATA_W-1:0] buf_d, buf_q;
  logic [HOLD_W-1:0] hold_d, hold_q;
  logic [HOLD_W-1:0] exe_fields, bus_fields;
  logic              req, use_hold;

  assign exe_fields = {exe_req_wr, exe_req_size, exe_req_addr, exe_req_wdata, exe_req_wstrb};
  // Bus fields read zero whenever no request is being presented.
  assign bus_fields = !req ? '0 : (use_hold ? hold_q : exe_fields);
  assign sram.data_sram_req = req;
  assign {sram.data_sram_wr, sram.data_sram_size, sram.data_sram_addr,
          sram.data_sram_wdata, sram.data_sram_wstrb} = bus_fields;

  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    buf_d          = buf_q;
    hold_d         = hold_q;
    req            = 1'b0;
    use_hold       = 1'b0;
    exe_req_accept = 1'b0;
    mem_data_ready = 1'b0;
    mem_rdata      = '0;
    case (state_q)
      ST_IDLE: begin
        req = exe_req_valid & ~flush;
        if (req) begin
          if (sram.data_sram_addr_ok) begin
            exe_req_accept = 1'b1;
            state_d        = ST_WAIT_DATA;
          end else begin
            hold_d  = exe_fields;
            state_d = ST_WAIT_ADDR;
          end
        end
      end
      ST_WAIT_ADDR: begin
        // The request cannot be withdrawn once shown; a flush only marks it for discard.
        req      = 1'b1;
        use_hold = 1'b1;
        drop_d   = drop_q | flush;
        if (sram.data_sram_addr_ok) begin
          exe_req_accept = ~drop_q & ~flush;
          state_d        = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        drop_d = drop_q | flush;
        if (sram.data_sram_data_ok) begin
          state_d = ST_IDLE;
          if (drop_q | flush) begin
            drop_d = 1'b0;
          end else begin
            mem_data_ready = 1'b1;
            mem_rdata      = sram.data_sram_rdata;
            if (!mem_advance) begin
              buf_d   = sram.data_sram_rdata;
              state_d = ST_DATA_BUF;
            end
          end
        end
      end
      ST_DATA_BUF: begin
        mem_data_ready = ~flush;
        mem_rdata      = flush ? '0 : buf_q;
        if (mem_advance | flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end
endmodule

// File: tb/tb_dsram_req_ctrl.sv
// Directed and randomized bench for dsram_req_ctrl with a transaction-level reference model.
module tb_dsram_req_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        exe_req_valid, exe_req_wr;
  logic [1:0]  exe_req_size;
  logic [31:0] exe_req_addr, exe_req_wdata;
  logic [3:0]  exe_req_wstrb;
  logic        exe_req_accept, mem_data_ready;
  logic [31:0] mem_rdata;
  logic        mem_advance, flush;

  int n_tests = 0;
  int n_fail  = 0;

  dsram_req_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  dsram_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .exe_req_valid  (exe_req_valid),
    .exe_req_wr     (exe_req_wr),
    .exe_req_size   (exe_req_size),
    .exe_req_addr   (exe_req_addr),
    .exe_req_wdata  (exe_req_wdata),
    .exe_req_wstrb  (exe_req_wstrb),
    .exe_req_accept (exe_req_accept),
    .mem_data_ready (mem_data_ready),
    .mem_rdata      (mem_rdata),
    .mem_advance    (mem_advance),
    .flush          (flush),
    .sram           (bus_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic req, input logic acc, input logic rdy);
    check({tag, ".req"}, 128'(bus_if.data_sram_req), 128'(req));
    check({tag, ".accept"}, 128'(exe_req_accept), 128'(acc));
    check({tag, ".ready"}, 128'(mem_data_ready), 128'(rdy));
  endtask

  function automatic logic [70:0] bus_fields();
    return {bus_if.data_sram_wr, bus_if.data_sram_size, bus_if.data_sram_addr,
            bus_if.data_sram_wdata, bus_if.data_sram_wstrb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic aok, input logic dok,
                       input logic [31:0] rd, input logic adv, input logic fl);
    exe_req_valid            = v;
    exe_req_wr               = wr;
    exe_req_size             = 2'd2;
    exe_req_addr             = addr;
    exe_req_wdata            = wdata;
    exe_req_wstrb            = 4'hF;
    bus_if.data_sram_addr_ok = aok;
    bus_if.data_sram_data_ok = dok;
    bus_if.data_sram_rdata   = rd;
    mem_advance              = adv;
    flush                    = fl;
  endtask

  // Reference transaction: timeline of one request measured in cycles from its first req cycle.
  logic        t_wr;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata, t_rsp;
  logic [3:0]  t_strb;
  int          a_lat, d_lat, m_lat, t_d, t_nom, t_end, f_at;
  logic        flushed, exp_req, exp_acc, exp_rdy;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    expect_out("reset", 0, 0, 0);
    check("reset.rdata", 128'(mem_rdata), 128'(0));
    check("reset.fields", 128'(bus_fields()), 128'(0));
    tick();

    // 1: zero-wait load
    drive(1, 0, 32'h100, 0, 1, 0, 0, 0, 0); #1;
    expect_out("t1.c0", 1, 1, 0);
    check("t1.c0.addr", 128'(bus_if.data_sram_addr), 128'(32'h100));
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0); #1;
    expect_out("t1.c1", 0, 0, 1);
    check("t1.c1.rdata", 128'(mem_rdata), 128'(32'h12345678));
    tick();

    // 2: store held through three addr_ok-low cycles; also proves IDLE after test 1
    drive(1, 1, 32'h1000, 32'hCAFEF00D, 0, 0, 0, 0, 0); #1;
    expect_out("t2.c0", 1, 0, 0);
    check("t2.c0.fields", 128'(bus_fields()), 128'({1'b1, 2'd2, 32'h1000, 32'hCAFEF00D, 4'hF}));
    tick();
    for (int i = 1; i < 3; i++) begin
      drive(1, 0, 32'h2000, 32'h0BADF00D, 0, 0, 0, 0, 0); #1;
      expect_out("t2.wait", 1, 0, 0);
      check("t2.wait.fields", 128'(bus_fields()), 128'({1'b1, 2'd2, 32'h1000, 32'hCAFEF00D, 4'hF}));
      tick();
    end
    drive(1, 0, 32'h2000, 32'h0BADF00D, 1, 0, 0, 0, 0); #1;
    expect_out("t2.aok", 1, 1, 0);
    check("t2.aok.addr", 128'(bus_if.data_sram_addr), 128'(32'h1000));
    tick();
    drive(0, 0, 0, 0, 0, 1, 0, 1, 0); #1;
    expect_out("t2.ack", 0, 0, 1);
    tick();

    // 3: flush in WAIT_DATA, data_ok two cycles later, then back-to-back request
    drive(1, 0, 32'h300, 0, 1, 0, 0, 0, 0); #1;
    expect_out("t3.issue", 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    expect_out("t3.flush", 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    expect_out("t3.gap", 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 0); #1;
    expect_out("t3.dok", 0, 0, 0);
    tick();
    drive(1, 0, 32'h304, 0, 1, 0, 0, 0, 0); #1;
    expect_out("t3.next", 1, 1, 0);
    check("t3.next.addr", 128'(bus_if.data_sram_addr), 128'(32'h304));
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h55, 1, 0); #1;
    expect_out("t3.next.dok", 0, 0, 1);
    check("t3.next.rdata", 128'(mem_rdata), 128'(32'h55));
    tick();

    // 4: flush in WAIT_ADDR, addr_ok next cycle; drop must clear afterwards
    drive(1, 0, 32'h400, 0, 0, 0, 0, 0, 0); #1;
    expect_out("t4.req", 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    expect_out("t4.flush", 1, 0, 0);
    check("t4.flush.addr", 128'(bus_if.data_sram_addr), 128'(32'h400));
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0); #1;
    expect_out("t4.aok", 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hBAD, 1, 0); #1;
    expect_out("t4.dok", 0, 0, 0);
    tick();
    drive(1, 0, 32'h408, 0, 1, 0, 0, 0, 0); #1;
    expect_out("t4.next", 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h77, 1, 0); #1;
    expect_out("t4.next.dok", 0, 0, 1);
    check("t4.next.rdata", 128'(mem_rdata), 128'(32'h77));
    tick();

    // 5: response buffered while MEM stalls two cycles
    drive(1, 0, 32'h500, 0, 1, 0, 0, 0, 0); #1;
    expect_out("t5.issue", 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'hA5A50001, 0, 0); #1;
    expect_out("t5.dok", 0, 0, 1);
    check("t5.dok.rdata", 128'(mem_rdata), 128'(32'hA5A50001));
    tick();
    drive(1, 0, 32'h600, 0, 1, 0, 32'h11111111, 0, 0); #1;
    expect_out("t5.buf1", 0, 0, 1);
    check("t5.buf1.rdata", 128'(mem_rdata), 128'(32'hA5A50001));
    tick();
    drive(1, 0, 32'h600, 0, 1, 0, 32'h22222222, 1, 0); #1;
    expect_out("t5.buf2", 0, 0, 1);
    check("t5.buf2.rdata", 128'(mem_rdata), 128'(32'hA5A50001));
    tick();
    drive(1, 0, 32'h600, 0, 1, 0, 0, 0, 0); #1;
    expect_out("t5.next", 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h66, 1, 0); #1;
    expect_out("t5.next.dok", 0, 0, 1);
    tick();

    // 6: reset in WAIT_ADDR and in DATA_BUF
    drive(1, 0, 32'h700, 0, 0, 0, 0, 0, 0); #1;
    expect_out("t6a.req", 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    expect_out("t6a.post", 0, 0, 0);
    tick();
    drive(1, 0, 32'h710, 0, 1, 0, 0, 0, 0); #1;
    expect_out("t6b.issue", 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 32'h99, 0, 0); #1;
    expect_out("t6b.dok", 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    expect_out("t6b.buf", 0, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    expect_out("t6b.post", 0, 0, 0);
    check("t6b.post.rdata", 128'(mem_rdata), 128'(0));
    tick();

    // Randomized transactions against the transaction-timeline model
    for (int n = 0; n < 200; n++) begin
      t_wr    = 1'($urandom_range(0, 1));
      t_size  = 2'($urandom_range(0, 2));
      t_addr  = $urandom;
      t_wdata = $urandom;
      t_strb  = 4'($urandom_range(1, 15));
      t_rsp   = $urandom;
      a_lat   = int'($urandom_range(0, 3));
      d_lat   = int'($urandom_range(0, 3));
      m_lat   = int'($urandom_range(0, 3));
      t_d     = a_lat + 1 + d_lat;
      t_nom   = t_d + m_lat;
      f_at    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, t_nom)) : 1000;
      if (f_at <= t_d)       t_end = t_d;
      else if (f_at < t_nom) t_end = f_at;
      else                   t_end = t_nom;
      for (int t = 0; t <= t_end; t++) begin
        if (t == 0) begin
          exe_req_valid = 1'b1;
          exe_req_wr    = t_wr;
          exe_req_size  = t_size;
          exe_req_addr  = t_addr;
          exe_req_wdata = t_wdata;
          exe_req_wstrb = t_strb;
        end else begin
          exe_req_valid = 1'($urandom_range(0, 1));
          exe_req_wr    = 1'($urandom_range(0, 1));
          exe_req_size  = 2'($urandom_range(0, 3));
          exe_req_addr  = $urandom;
          exe_req_wdata = $urandom;
          exe_req_wstrb = 4'($urandom);
        end
        bus_if.data_sram_addr_ok = (t == a_lat);
        bus_if.data_sram_data_ok = (t == t_d);
        bus_if.data_sram_rdata   = (t == t_d) ? t_rsp : $urandom;
        mem_advance              = (t == t_nom);
        flush                    = (t == f_at);
        #1;
        flushed = (f_at <= t);
        exp_req = (t <= a_lat);
        exp_acc = (t == a_lat) && !flushed;
        exp_rdy = (t >= t_d) && !flushed;
        expect_out("rnd", exp_req, exp_acc, exp_rdy);
        if (exp_req)
          check("rnd.fields", 128'(bus_fields()), 128'({t_wr, t_size, t_addr, t_wdata, t_strb}));
        if (exp_rdy && !t_wr)
          check("rnd.rdata", 128'(mem_rdata), 128'(t_rsp));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
